// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 8-bit ALU between requesters A and B.
// Build option: define ALU_ARB_FIXED_PRIO_EN for strict A priority (no round-robin pointer).
`ifndef ALUOP_PD1
`define ALUOP_PD1 4'h0
`endif
`ifndef ALUOP_PD2
`define ALUOP_PD2 4'h1
`endif
`ifndef ALUOP_ADD
`define ALUOP_ADD 4'h2
`endif
`ifndef ALUOP_ZER
`define ALUOP_ZER 4'h3
`endif

module alu_arbiter (
   input  logic       i_Clock,
   input  logic       i_Reset,
   input  logic       i_ReqA,
   input  logic [3:0] i_OpA,
   input  logic [7:0] i_Data1A,
   input  logic [7:0] i_Data2A,
   input  logic       i_ReqB,
   input  logic [3:0] i_OpB,
   input  logic [7:0] i_Data1B,
   input  logic [7:0] i_Data2B,
   output logic       o_GntA,
   output logic       o_GntB,
   output logic       o_DoneA,
   output logic       o_DoneB,
   output logic [7:0] o_Result,
   output logic       o_Z,
   output logic       o_S,
   output logic       o_C,
   output logic       o_OF,
   output logic       o_IllegalOp,
   output logic       o_Busy,
   output logic [7:0] o_ALUData1,
   output logic [7:0] o_ALUData2,
   output logic [3:0] o_ALUOp,
   input  logic [7:0] i_ALUResult,
   input  logic       i_ALUZ,
   input  logic       i_ALUS,
   input  logic       i_ALUC,
   input  logic       i_ALUOF
);

   typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_t;

   state_t state, state_nxt;
   logic   owner_b;
   logic   illegal_q;
   logic   accept;
   logic   win_b;

`ifdef ALU_ARB_FIXED_PRIO_EN
   always_comb win_b = i_ReqB & ~i_ReqA;
`else
   // last_b = 1 means B was granted last, so A wins the next tie
   logic last_b;

   always_comb win_b = i_ReqB & (~i_ReqA | ~last_b);

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset)     last_b <= 1'b1;
      else if (accept) last_b <= win_b;
   end
`endif

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      accept      = 1'b0;
      o_GntA      = 1'b0;
      o_GntB      = 1'b0;
      o_DoneA     = 1'b0;
      o_DoneB     = 1'b0;
      o_IllegalOp = 1'b0;
      o_Busy      = 1'b0;
      case (state)
         ST_IDLE: begin
            accept = i_ReqA | i_ReqB;
            if (accept) state_nxt = ST_EXEC;
         end
         ST_EXEC: begin
            state_nxt = ST_DONE;
            o_GntA    = ~owner_b;
            o_GntB    = owner_b;
            o_Busy    = 1'b1;
         end
         ST_DONE: begin
            accept      = i_ReqA | i_ReqB;
            state_nxt   = accept ? ST_EXEC : ST_IDLE;
            o_DoneA     = ~owner_b;
            o_DoneB     = owner_b;
            o_IllegalOp = illegal_q;
            o_Busy      = 1'b1;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         owner_b    <= 1'b0;
         illegal_q  <= 1'b0;
         o_ALUData1 <= '0;
         o_ALUData2 <= '0;
         o_ALUOp    <= `ALUOP_ZER;
         o_Result   <= '0;
         o_Z        <= 1'b0;
         o_S        <= 1'b0;
         o_C        <= 1'b0;
         o_OF       <= 1'b0;
      end else begin
         if (accept) begin
            owner_b    <= win_b;
            o_ALUOp    <= win_b ? i_OpB    : i_OpA;
            o_ALUData1 <= win_b ? i_Data1B : i_Data1A;
            o_ALUData2 <= win_b ? i_Data2B : i_Data2A;
         end
         // ALU output has settled on the registered operands by the end of EXEC
         if (state == ST_EXEC) begin
            illegal_q <= 1'b0;
            case (o_ALUOp)
               `ALUOP_ADD: begin
                  o_Result <= i_ALUResult;
                  o_Z      <= i_ALUZ;
                  o_S      <= i_ALUS;
                  o_C      <= i_ALUC;
                  o_OF     <= i_ALUOF;
               end
               `ALUOP_ZER: begin
                  o_Result <= i_ALUResult;
                  o_Z      <= 1'b1;
               end
               `ALUOP_PD1, `ALUOP_PD2: o_Result <= i_ALUResult;
               default: illegal_q <= 1'b1;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors for alu_arbiter with a behavioural ALU attached.
`ifndef ALUOP_PD1
`define ALUOP_PD1 4'h0
`endif
`ifndef ALUOP_PD2
`define ALUOP_PD2 4'h1
`endif
`ifndef ALUOP_ADD
`define ALUOP_ADD 4'h2
`endif
`ifndef ALUOP_ZER
`define ALUOP_ZER 4'h3
`endif

module tb_alu_arbiter;
   logic       clk, rst;
   logic       req_a, req_b;
   logic [3:0] op_a, op_b;
   logic [7:0] d1_a, d2_a, d1_b, d2_b;
   logic       gnt_a, gnt_b, done_a, done_b;
   logic [7:0] result;
   logic       z, s, c, ovf, illegal, busy;
   logic [7:0] alu_d1, alu_d2, alu_res;
   logic [3:0] alu_op;
   logic       alu_z, alu_s, alu_c, alu_of;
   logic [8:0] sum;
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   alu_arbiter dut (
      .i_Clock(clk), .i_Reset(rst),
      .i_ReqA(req_a), .i_OpA(op_a), .i_Data1A(d1_a), .i_Data2A(d2_a),
      .i_ReqB(req_b), .i_OpB(op_b), .i_Data1B(d1_b), .i_Data2B(d2_b),
      .o_GntA(gnt_a), .o_GntB(gnt_b), .o_DoneA(done_a), .o_DoneB(done_b),
      .o_Result(result), .o_Z(z), .o_S(s), .o_C(c), .o_OF(ovf),
      .o_IllegalOp(illegal), .o_Busy(busy),
      .o_ALUData1(alu_d1), .o_ALUData2(alu_d2), .o_ALUOp(alu_op),
      .i_ALUResult(alu_res), .i_ALUZ(alu_z), .i_ALUS(alu_s), .i_ALUC(alu_c), .i_ALUOF(alu_of)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural ALU; illegal opcodes produce a recognisable junk value
   always_comb begin
      sum     = {1'b0, alu_d1} + {1'b0, alu_d2};
      alu_res = 8'hEE;
      alu_c   = 1'b0;
      alu_of  = 1'b0;
      case (alu_op)
         `ALUOP_PD1: alu_res = alu_d1;
         `ALUOP_PD2: alu_res = alu_d2;
         `ALUOP_ADD: begin
            alu_res = sum[7:0];
            alu_c   = sum[8];
            alu_of  = (alu_d1[7] == alu_d2[7]) && (sum[7] != alu_d1[7]);
         end
         `ALUOP_ZER: alu_res = 8'h00;
         default: alu_res = 8'hEE;
      endcase
      alu_z = (alu_res == 8'h00);
      alu_s = alu_res[7];
   end

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // one request from a single requester, through grant, done and back to idle
   task automatic run_op(input logic is_b, input logic [3:0] op, input logic [7:0] a1, input logic [7:0] a2);
      int unsigned n;
      if (is_b) begin req_b = 1'b1; op_b = op; d1_b = a1; d2_b = a2; end
      else      begin req_a = 1'b1; op_a = op; d1_a = a1; d2_a = a2; end
      n = 0;
      tick;
      while (!(gnt_a | gnt_b) && n < 8) begin tick; n++; end
      check_vec("gnt_a", {31'b0, gnt_a}, {31'b0, ~is_b});
      check_vec("gnt_b", {31'b0, gnt_b}, {31'b0, is_b});
      req_a = 1'b0;
      req_b = 1'b0;
      tick;
      check_vec("done_a", {31'b0, done_a}, {31'b0, ~is_b});
      check_vec("done_b", {31'b0, done_b}, {31'b0, is_b});
      check_vec("illegal", {31'b0, illegal},
                {31'b0, !(op inside {`ALUOP_PD1, `ALUOP_PD2, `ALUOP_ADD, `ALUOP_ZER})});
      tick;
      check_vec("idle_busy", {31'b0, busy}, 32'd0);
      check_vec("alu_op_hold", {28'b0, alu_op}, {28'b0, op});
   endtask

   initial begin
      logic exp_a;
      rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
      op_a = '0; op_b = '0; d1_a = '0; d2_a = '0; d1_b = '0; d2_b = '0;
      #12 rst = 1'b0;
      #1;
      check_vec("rst_result", {24'b0, result}, 32'h00);
      check_vec("rst_flags", {28'b0, z, s, c, ovf}, 32'h0);
      check_vec("rst_aluop", {28'b0, alu_op}, {28'b0, `ALUOP_ZER});
      check_vec("rst_busy", {29'b0, busy, gnt_a, gnt_b}, 32'h0);

      run_op(1'b0, `ALUOP_ADD, 8'h7F, 8'h01);
      check_vec("a_add_res", {24'b0, result}, 32'h80);
      check_vec("a_add_flg", {28'b0, z, s, c, ovf}, 32'b0101);
      run_op(1'b1, `ALUOP_ADD, 8'hFF, 8'h01);
      check_vec("b_add_res", {24'b0, result}, 32'h00);
      check_vec("b_add_flg", {28'b0, z, s, c, ovf}, 32'b1010);
      run_op(1'b1, `ALUOP_PD1, 8'h5A, 8'h33);
      check_vec("b_pd1_res", {24'b0, result}, 32'h5A);
      check_vec("b_pd1_flg", {28'b0, z, s, c, ovf}, 32'b1010);
      run_op(1'b0, `ALUOP_ADD, 8'h7F, 8'h01);
      check_vec("a_add2_flg", {28'b0, z, s, c, ovf}, 32'b0101);
      run_op(1'b0, `ALUOP_ZER, 8'h12, 8'h34);
      check_vec("a_zer_res", {24'b0, result}, 32'h00);
      check_vec("a_zer_flg", {28'b0, z, s, c, ovf}, 32'b1101);
      run_op(1'b0, 4'hF, 8'h12, 8'h34);
      check_vec("a_ill_res", {24'b0, result}, 32'h00);
      check_vec("a_ill_flg", {28'b0, z, s, c, ovf}, 32'b1101);
      run_op(1'b1, `ALUOP_PD2, 8'h12, 8'hC3);
      check_vec("b_pd2_res", {24'b0, result}, 32'hC3);
      check_vec("b_pd2_flg", {28'b0, z, s, c, ovf}, 32'b1101);

      // both requesters held high: B was granted last, so A leads the alternation
      req_a = 1'b1; op_a = `ALUOP_PD1; d1_a = 8'h11; d2_a = 8'h99;
      req_b = 1'b1; op_b = `ALUOP_PD2; d1_b = 8'h99; d2_b = 8'h22;
      for (int k = 0; k < 8; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         exp_a = 1'b1;
`else
         exp_a = (k % 2 == 0);
`endif
         tick;
         check_vec("rr_gnt_a", {31'b0, gnt_a}, {31'b0, exp_a});
         check_vec("rr_gnt_b", {31'b0, gnt_b}, {31'b0, ~exp_a});
         tick;
         check_vec("rr_done_a", {31'b0, done_a}, {31'b0, exp_a});
         check_vec("rr_done_b", {31'b0, done_b}, {31'b0, ~exp_a});
         check_vec("rr_result", {24'b0, result}, exp_a ? 32'h11 : 32'h22);
         if (k == 7) begin req_a = 1'b0; req_b = 1'b0; end
      end
      tick;
      check_vec("rr_idle", {31'b0, busy}, 32'd0);

      // asynchronous reset while A's ADD is in EXEC
      req_a = 1'b1; op_a = `ALUOP_ADD; d1_a = 8'h01; d2_a = 8'h02;
      tick;
      check_vec("pre_rst_gnt", {31'b0, gnt_a}, 32'd1);
      req_a = 1'b0;
      #2 rst = 1'b1;
      #1;
      check_vec("arst_busy", {29'b0, busy, gnt_a, gnt_b}, 32'h0);
      check_vec("arst_result", {24'b0, result}, 32'h00);
      check_vec("arst_flags", {28'b0, z, s, c, ovf}, 32'h0);
      check_vec("arst_aluop", {28'b0, alu_op}, {28'b0, `ALUOP_ZER});
      tick;
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick;
         check_vec("no_done_a", {30'b0, done_a, busy}, 32'h0);
      end
      req_a = 1'b1; req_b = 1'b1;
      op_a = `ALUOP_PD1; op_b = `ALUOP_PD1;
      tick;
      check_vec("post_rst_gnt_a", {31'b0, gnt_a}, 32'd1);
      check_vec("post_rst_gnt_b", {31'b0, gnt_b}, 32'd0);
      req_a = 1'b0; req_b = 1'b0;
      tick;
      tick;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 8-bit ALU between two requesters: A (instruction execute) and B (address/auxiliary unit).
- Arbitrates requests, latches operands and opcode, and drives the ALU operand/opcode lines from registers.
- Captures the ALU result one cycle later and returns it, with a held flag register (Z, S, C, OF), to the winning requester.
- Sits between the control unit and the ALU; the ALU stays purely combinational.

Parameters:
- none; widths are fixed at 8-bit data and 4-bit opcode, matching the ALU and the `ALUOP_* macros in Constants.v.

Ports:
- i_Clock  in  1  system clock, rising edge
- i_Reset  in  1  asynchronous, active-high reset
- i_ReqA  in  1  requester A wants an ALU operation
- i_OpA  in  4  A opcode (`ALUOP_*)
- i_Data1A  in  8  A operand 1
- i_Data2A  in  8  A operand 2
- i_ReqB, i_OpB, i_Data1B, i_Data2B  in  1/4/8/8  same for requester B
- o_GntA, o_GntB  out  1  one-cycle pulse: request accepted, operands captured
- o_DoneA, o_DoneB  out  1  one-cycle pulse: o_Result/flags valid for that requester
- o_Result  out  8  registered result of last completed op
- o_Z, o_S, o_C, o_OF  out  1  registered flag register
- o_IllegalOp  out  1  one-cycle pulse alongside Done when the opcode is not PD1/PD2/ADD/ZER
- o_Busy  out  1  high in EXEC and DONE
- o_ALUData1, o_ALUData2  out  8  registered operands to ALU
- o_ALUOp  out  4  registered opcode to ALU
- i_ALUResult  in  8  ALU o_Result
- i_ALUZ, i_ALUS, i_ALUC, i_ALUOF  in  1  ALU flags

Behaviour:
- Reset (async, any state):
  - state IDLE; all Gnt/Done/IllegalOp/Busy 0.
  - o_Result 8'h00; all flags 0.
  - o_ALUData1/2 8'h00; o_ALUOp `ALUOP_ZER.
  - Round-robin pointer = "B last", so A wins first.
  - An in-flight op is aborted; no Done is issued.
- FSM states:
  - IDLE -> EXEC on any accepted request.
  - EXEC -> DONE unconditionally.
  - DONE -> EXEC if a request is accepted this edge, else IDLE.
- Accept: at a rising edge in IDLE or DONE with i_ReqA|i_ReqB.
  - Winner's opcode and operands are loaded into the o_ALU* registers.
  - The owner register is set; the matching o_Gnt is high for the following cycle (EXEC).
- Requester holds Req and operands stable until it sees Gnt. Req still high in the Gnt cycle is ignored, since EXEC does not accept.
- Req high again in the DONE cycle is a new request.
- Arbitration (default): only one requesting -> it wins; both -> the one not granted last wins. The pointer updates on each grant.
- EXEC: ALU settles combinationally on the registered inputs. At the EXEC->DONE edge:
  - o_Result <= i_ALUResult.
  - Flag update by opcode:
    - ADD: Z, S, OF from ALU; C <= i_ALUC.
    - ZER: Z <= 1, S/C/OF unchanged.
    - PD1/PD2: all flags unchanged.
    - Illegal opcode: o_Result and flags unchanged; o_IllegalOp pulses in DONE.
- DONE: the owner's o_Done is high for exactly one cycle; o_Result/flags hold until the next completion.
- Latency: request sampled at edge N -> Gnt in cycle N+1 -> Done in cycle N+2. Back-to-back throughput is one op per 2 cycles.
- Continuous requests from both requesters alternate grants strictly A, B, A, B.
- o_ALU* registers hold their last value in IDLE, with no spurious opcode changes.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: requester A always wins simultaneous requests, and the round-robin pointer is removed. B can starve; this is intended.
- Undefined: round-robin as above.

Test Plan:
- Reset, then A: ADD 8'h7F + 8'h01 -> GntA next cycle, DoneA the cycle after; o_Result 8'h80, S=1, OF=1, Z=0; B signals stay 0.
- B: ADD 8'hFF + 8'h01 -> DoneB, o_Result 8'h00, Z=1, S=0, OF=0. Then B: PD1 8'h5A -> o_Result 8'h5A with Z still 1.
- ReqA and ReqB both held high for 8 ops -> grant order A, B, A, B, …; each Done goes to the correct owner. With ALU_ARB_FIXED_PRIO_EN defined, all 8 go to A.
- A: ZER after S=1 -> o_Result 8'h00, Z=1, S still 1. Opcode 4'hF -> o_IllegalOp and DoneA pulse, o_Result and flags unchanged.
- Assert i_Reset asynchronously mid-EXEC -> outputs go to reset values immediately; no Done after release; the next simultaneous request grants A first.
